// File: rtl/shared_pkg.sv
// Constants and the data word type shared by the FIFO and its read-side adapter.
package shared_pkg;

  localparam int FIFO_WIDTH    = 16;
  localparam int FIFO_DEPTH    = 16;
  localparam int BUF_DEPTH_DEF = 2;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_adapter_if.sv
// Bundle of the FIFO read port and the downstream stream between FIFO, adapter and consumer.
interface fifo_rd_adapter_if #(
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH
);

  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;

  // Stream: a word transfers on every clock edge where m_valid and m_ready are both 1.
  // Once m_valid is raised, m_valid and m_data hold until that transfer happens.
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_data_out, fifo_underflow, m_ready,
    output fifo_rd_en, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_data_out, fifo_underflow, m_ready,
    input  fifo_rd_en, m_data, m_valid
  );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Small circular skid buffer: push/pop pointers with wrap, an entry count and a synchronous flush.
module fifo_rd_skid_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      // A simultaneous push and pop leaves the count unchanged, even when full.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Read-side adapter: issues FIFO reads, absorbs the one-cycle read latency and re-presents words as a stream.
// Optional counters beat_cnt/stall_cnt are built when FIFO_RD_ADAPTER_STATS_EN is defined.
module fifo_rd_adapter
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fifo_rd_adapter_if.master   bus,
  output logic [CNT_W-1:0]    occupancy,
  output logic                err_underflow
`ifdef FIFO_RD_ADAPTER_STATS_EN
  ,
  output logic [31:0]         beat_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int LVL_W = CNT_W + 1;

  logic                  inflight;
  logic                  pop;
  logic                  push;
  logic                  m_valid;
  logic [CNT_W-1:0]      count;
  logic [LVL_W-1:0]      level;
  logic [FIFO_WIDTH-1:0] rd_data;

  assign m_valid = (count != '0);
  assign pop     = m_valid & bus.m_ready;
  assign push    = inflight & ~flush;

  // Slots already committed once this cycle's pop leaves; m_ready reaches fifo_rd_en combinationally.
  assign level = LVL_W'(count) + LVL_W'(inflight) - LVL_W'(pop);

  assign bus.fifo_rd_en = ~bus.fifo_empty & ~flush & (level < LVL_W'(BUF_DEPTH));
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = rd_data;
  assign occupancy      = count;

  fifo_rd_skid_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.fifo_data_out),
    .pop       (pop),
    .flush     (flush),
    .rd_data   (rd_data),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= bus.fifo_rd_en;
      if (inflight && bus.fifo_underflow) err_underflow <= 1'b1;
    end
  end

`ifdef FIFO_RD_ADAPTER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (beat_cnt != '1)) beat_cnt <= beat_cnt + 32'd1;
      if (m_valid && !bus.m_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: FIFO model, queue-level reference of the skid buffer, vector table and random phase.
module tb_fifo_rd_adapter;

  localparam int W     = 16;
  localparam int DEPTH = 2;

  typedef logic [W-1:0] word_t;

  typedef struct {
    bit    rdy;
    bit    fl;
    bit    valid;
    word_t data;
    bit    rd_en;
    int    occ;
  } vec_t;

  // clock / reset
  logic clk;
  logic rst_n;
  logic flush;
  logic [1:0] occupancy;
  logic err_underflow;
`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] stall_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_adapter_if #(.FIFO_WIDTH(W)) bus ();

  fifo_rd_adapter #(.FIFO_WIDTH(W), .BUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .bus           (bus.master),
    .occupancy     (occupancy),
    .err_underflow (err_underflow)
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    .beat_cnt      (beat_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  // bench state: FIFO contents, reference buffer, scoreboard
  word_t fifo_q[$];
  word_t mdl_buf[$];
  bit    mdl_inflight;
  bit    mdl_err;
  int    mdl_beats;
  int    mdl_stalls;
  bit    force_uf;
  word_t delivered[$];
  word_t exp_q[$];
  int    rd_pulses;
  bit    tbl_en;
  vec_t  cur_vec;
  vec_t  tbl[11];
  int    n_vec;
  int    n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_buf.delete();
    mdl_inflight = 1'b0;
    mdl_err      = 1'b0;
    mdl_beats    = 0;
    mdl_stalls   = 0;
  endtask

  // One clock cycle: drive, sample mid-cycle, check against the reference, advance model and FIFO.
  task automatic step(input bit rdy, input bit fl);
    bit    exp_valid;
    bit    pop;
    bit    exp_rd;
    bit    rd_now;
    bit    uf_pre;
    int    lvl;
    word_t data_pre;
    bus.m_ready    = rdy;
    flush          = fl;
    bus.fifo_empty = (fifo_q.size() == 0);
    #2;
    exp_valid = (mdl_buf.size() != 0);
    pop       = exp_valid && rdy;
    lvl       = mdl_buf.size() + int'(mdl_inflight) - int'(pop);
    exp_rd    = !bus.fifo_empty && !fl && (lvl < DEPTH);
    check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(bus.m_data), 32'(mdl_buf[0]));
    check("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
    check("occupancy", 32'(occupancy), 32'(mdl_buf.size()));
    check("occ_bound", 32'(occupancy <= DEPTH), 32'd1);
    check("err_underflow", 32'(err_underflow), 32'(mdl_err));
    if (tbl_en) begin
      check("tbl_m_valid", 32'(bus.m_valid), 32'(cur_vec.valid));
      if (cur_vec.valid) check("tbl_m_data", 32'(bus.m_data), 32'(cur_vec.data));
      check("tbl_fifo_rd_en", 32'(bus.fifo_rd_en), 32'(cur_vec.rd_en));
      check("tbl_occupancy", 32'(occupancy), 32'(cur_vec.occ));
    end
    rd_now   = bus.fifo_rd_en;
    uf_pre   = bus.fifo_underflow;
    data_pre = bus.fifo_data_out;
    if (rd_now) rd_pulses++;
    if (bus.m_valid && rdy) delivered.push_back(bus.m_data);
    if (pop) mdl_beats++;
    if (exp_valid && !rdy) mdl_stalls++;
    @(posedge clk);
    if (mdl_inflight && uf_pre) mdl_err = 1'b1;
    if (fl) begin
      mdl_buf.delete();
    end else begin
      if (pop) void'(mdl_buf.pop_front());
      if (mdl_inflight) mdl_buf.push_back(data_pre);
    end
    mdl_inflight = exp_rd;
    #1;
    bus.fifo_underflow = 1'b0;
    if (rd_now) begin
      if (fifo_q.size() != 0) begin
        bus.fifo_data_out = fifo_q.pop_front();
      end else begin
        bus.fifo_data_out  = '0;
        bus.fifo_underflow = 1'b1;
      end
      if (force_uf) bus.fifo_underflow = 1'b1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mdl_buf.size() != 0 || mdl_inflight || fifo_q.size() != 0) && guard < 100) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("drain_within_budget", 32'(guard < 100), 32'd1);
    step(1'b1, 1'b0);
  endtask

  task automatic check_order(input string name);
    check({name, "_count"}, 32'(delivered.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < delivered.size(); i++)
      check({name, "_word"}, 32'(delivered[i]), 32'(exp_q[i]));
    delivered.delete();
    exp_q.delete();
  endtask

  task automatic load(input word_t base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + word_t'(i));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl_en = 1'b0;
    force_uf = 1'b0;
    rd_pulses = 0;
    model_reset();
    rst_n              = 1'b0;
    flush              = 1'b0;
    bus.m_ready        = 1'b0;
    bus.fifo_empty     = 1'b1;
    bus.fifo_data_out  = '0;
    bus.fifo_underflow = 1'b0;

    // Test 1 and test 2 stall expectations
    tbl[0]  = '{1, 0, 0, 16'h0000, 1, 0};
    tbl[1]  = '{1, 0, 0, 16'h0000, 1, 0};
    tbl[2]  = '{1, 0, 1, 16'h0011, 1, 1};
    tbl[3]  = '{1, 0, 1, 16'h0022, 0, 1};
    tbl[4]  = '{1, 0, 1, 16'h0033, 0, 1};
    tbl[5]  = '{1, 0, 0, 16'h0000, 0, 0};
    tbl[6]  = '{0, 0, 0, 16'h0000, 1, 0};
    tbl[7]  = '{0, 0, 0, 16'h0000, 1, 0};
    tbl[8]  = '{0, 0, 1, 16'h00A0, 0, 1};
    tbl[9]  = '{0, 0, 1, 16'h00A0, 0, 2};
    tbl[10] = '{0, 0, 1, 16'h00A0, 0, 2};

    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_err_underflow", 32'(err_underflow), 32'd0);
    rst_n = 1'b1;

    // Preloaded three words, consumer always ready
    fifo_q = '{16'h0011, 16'h0022, 16'h0033};
    tbl_en = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      cur_vec = tbl[i];
      step(cur_vec.rdy, cur_vec.fl);
    end
    tbl_en = 1'b0;
    exp_q = '{16'h0011, 16'h0022, 16'h0033};
    check_order("preload3");

    // Eight words, five stalled cycles
    load(16'h00A0, 8);
    rd_pulses = 0;
    tbl_en = 1'b1;
    for (int i = 6; i <= 10; i++) begin
      cur_vec = tbl[i];
      step(cur_vec.rdy, cur_vec.fl);
    end
    tbl_en = 1'b0;
    check("stall_rd_pulses", 32'(rd_pulses), 32'd2);
    drain();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h00A0 + word_t'(i));
    check_order("stall8");

    // m_ready toggling every cycle
    load(16'h00B0, 10);
    for (int i = 0; i < 30; i++) step(i[0] == 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h00B0 + word_t'(i));
    check_order("toggle10");

    // Flush with one buffered word and one read in flight, consumer ready
    load(16'h00C0, 6);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    drain();
    exp_q = '{16'h00C0, 16'h00C2, 16'h00C3, 16'h00C4, 16'h00C5};
    check_order("flush_inflight");

    // Flush with a full buffer
    load(16'h00D0, 4);
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    drain();
    exp_q = '{16'h00D2, 16'h00D3};
    check_order("flush_full");

    // Underflow flag while no read is in flight must be ignored
    bus.fifo_underflow = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("uf_idle_ignored", 32'(err_underflow), 32'd0);

    // Underflow reported on an adapter-issued read is sticky
    fifo_q.push_back(16'h00EE);
    force_uf = 1'b1;
    step(1'b1, 1'b0);
    force_uf = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("uf_set", 32'(err_underflow), 32'd1);
    drain();
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    check("uf_sticky", 32'(err_underflow), 32'd1);
    delivered.delete();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      if ($urandom_range(0, 2) != 0) fifo_q.push_back(word_t'($urandom));
    end
    drain();
    delivered.delete();

    // Reset asserted mid-stream with a full buffer
    load(16'h00F0, 6);
    repeat (4) step(1'b0, 1'b0);
    check("pre_rst_occupancy", 32'(occupancy), 32'd2);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check("beat_cnt", beat_cnt, 32'(mdl_beats));
    check("stall_cnt", stall_cnt, 32'(mdl_stalls));
`endif
    rst_n = 1'b0;
    fifo_q.delete();
    bus.fifo_empty    = 1'b1;
    bus.fifo_data_out = '0;
    #1;
    check("async_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("async_rst_occupancy", 32'(occupancy), 32'd0);
    check("async_rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("async_rst_err_underflow", 32'(err_underflow), 32'd0);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check("rst_beat_cnt", beat_cnt, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    delivered.delete();

    // Traffic after reset
    load(16'h0100, 5);
    for (int i = 0; i < 12; i++) step(i % 3 != 0, 1'b0);
    drain();
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0100 + word_t'(i));
    check_order("post_reset");
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check("final_beat_cnt", beat_cnt, 32'(mdl_beats));
    check("final_stall_cnt", stall_cnt, 32'(mdl_stalls));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
